// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus widths, target FSM state encoding, R/W bit values.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_WIDTH = 7;
  localparam int unsigned I2C_DATA_WIDTH = 8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Bus bundle of the I2C register target.
//   scl_i/sda_i : wired-AND bus levels seen by the target
//   sda_o       : open-drain data drive (0 = pull low, 1 = release)
//   busy_o      : transaction addressed to this target in progress
//   wr_stb_o/wr_addr_o/wr_data_o : register write notification
interface i2c_target_regs_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          scl_i;
  logic          sda_i;
  logic          sda_o;
  logic          busy_o;
  logic          wr_stb_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;

  modport slave (
    input  scl_i, sda_i,
    output sda_o, busy_o, wr_stb_o, wr_addr_o, wr_data_o
  );

  modport master (
    output scl_i, sda_i,
    input  sda_o, busy_o, wr_stb_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/i2c_line_sync.sv
// 2-FF synchronizers for SCL/SDA plus registered edge and START/STOP detection.
//   clk_i, rstn_i      : system clock, async active-low reset
//   scl_i, sda_i       : raw bus levels
//   scl_rise, scl_fall : one-cycle pulses on synced SCL edges
//   start_det, stop_det: one-cycle pulses on START / STOP conditions
//   sda_smp            : synced SDA aligned with the pulses above
module i2c_line_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_smp
);

  // [1:0] synchronizer stages, [2] one-cycle-delayed synced copy
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scl_sh    <= 3'b111;
      sda_sh    <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_smp   <= 1'b1;
    end else begin
      scl_sh    <= {scl_sh[1:0], scl_i};
      sda_sh    <= {sda_sh[1:0], sda_i};
      scl_rise  <= scl_sh[1] & ~scl_sh[2];
      scl_fall  <= ~scl_sh[1] & scl_sh[2];
      // SDA moving while SCL is stably high is a bus condition, not data
      start_det <= scl_sh[1] & scl_sh[2] & sda_sh[2] & ~sda_sh[1];
      stop_det  <= scl_sh[1] & scl_sh[2] & ~sda_sh[2] & sda_sh[1];
      sda_smp   <= sda_sh[1];
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a pointer-addressed register file: first write byte loads
// the pointer, further write bytes store and auto-increment, reads stream
// mem[ptr] with auto-increment. Never stretches SCL.
//   clk_i, rstn_i : system clock, async active-low reset
//   bus           : i2c_target_regs_if slave (scl/sda, busy, write notify)
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
  parameter int unsigned               DEPTH      = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  i2c_target_regs_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = I2C_DATA_WIDTH;

  logic scl_rise, scl_fall, start_det, stop_det, sda_smp;

  i2c_line_sync u_sync (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_smp   (sda_smp)
  );

  i2c_tgt_state_t state_q, state_d;

  logic [DW-1:0] shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          phase_q, phase_d;   // ack slot: 0 = not yet driven, 1 = driving
  logic          first_q, first_d;   // next write byte is the pointer
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_q, sda_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          mem_we;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_byte;
  logic [DW-1:0] rx_byte;
  logic          addr_match;

  assign rd_byte    = mem[ptr_q];
  assign rx_byte    = {shreg_q[DW-2:0], sda_smp};
  assign addr_match = (shreg_q[DW-1:1] == SLAVE_ADDR);

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; STOP beats START beats SCL edges
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:     if (scl_rise && bit_cnt_q == 3'd7) state_d = ADDR_ACK;
        ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                      if (!addr_match) state_d = IGNORE;
                    end else begin
                      state_d = (shreg_q[0] == I2C_RW_READ) ? RD_BYTE : WR_BYTE;
                    end
                  end
        WR_BYTE:  if (scl_rise && bit_cnt_q == 3'd7) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && phase_q) state_d = WR_BYTE;
        RD_BYTE:  if (scl_fall && bit_cnt_q == 3'd7) state_d = RD_ACK;
        RD_ACK:   if (scl_rise && sda_smp) state_d = IGNORE;
                  else if (scl_fall)       state_d = RD_BYTE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    first_d   = first_q;
    ptr_d     = ptr_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (stop_det) begin
      sda_d  = 1'b1;
      busy_d = 1'b0;
    end else if (start_det) begin
      sda_d     = 1'b1;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            if (addr_match) begin
              sda_d   = 1'b0;
              busy_d  = 1'b1;
              phase_d = 1'b1;
            end
          end else begin
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            if (shreg_q[0] == I2C_RW_READ) begin
              shreg_d = rd_byte;
              sda_d   = rd_byte[DW-1];
              ptr_d   = AW'(ptr_q + 1'b1);
            end else begin
              sda_d   = 1'b1;
              first_d = 1'b1;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            if (first_q) begin
              ptr_d   = rx_byte[AW-1:0];
              first_d = 1'b0;
            end else begin
              mem_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = AW'(ptr_q + 1'b1);
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_d   = 1'b0;
            phase_d = 1'b1;
          end else begin
            sda_d     = 1'b1;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
          end
        end
        // MSB was presented at load; each later fall presents the next bit,
        // the eighth fall hands SDA back for the master's ack
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_d     = 1'b1;
            bit_cnt_d = 3'd0;
          end else begin
            shreg_d   = {shreg_q[DW-2:0], 1'b0};
            sda_d     = shreg_q[DW-2];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_smp) begin
            busy_d = 1'b0;
          end else if (scl_fall) begin
            shreg_d   = rd_byte;
            sda_d     = rd_byte[DW-1];
            ptr_d     = AW'(ptr_q + 1'b1);
            bit_cnt_d = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= 3'd0;
      phase_q   <= 1'b0;
      first_q   <= 1'b0;
      ptr_q     <= '0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      first_q   <= first_d;
      ptr_q     <= ptr_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[ptr_q] <= rx_byte;
    end
  end

  assign bus.sda_o     = sda_q;
  assign bus.busy_o    = busy_q;
  assign bus.wr_stb_o  = wr_stb_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master, register model,
// scoreboard queues for acks, read data and write strobes.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned Q     = 8;   // quarter SCL period in clk cycles

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_exp_t;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_target_regs_if #(.DEPTH(DEPTH)) bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & bus.sda_o;

  i2c_target_regs #(.SLAVE_ADDR(7'h22), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int stb_cnt  = 0;

  logic [7:0]    model_mem [DEPTH];
  logic [AW-1:0] model_ptr = '0;
  logic [7:0]    rd_q [$];
  logic          ack_q [$];
  wr_exp_t       wr_q [$];
  logic          watch_low = 1'b0;
  logic          saw_low   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = bus.sda_i; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    chk(tag, 32'(a), 32'(ack_q.pop_front()));
  endtask

  task automatic wr_ptr(input logic [7:0] p);
    send_byte("ptr_ack", p, 1'b0);
    model_ptr = p[AW-1:0];
  endtask

  task automatic wr_data(input logic [7:0] b);
    wr_q.push_back('{addr: model_ptr, data: b});
    model_mem[model_ptr] = b;
    model_ptr = AW'(model_ptr + 1'b1);
    send_byte("data_ack", b, 1'b0);
  endtask

  task automatic rd_one(input string tag, input logic nack);
    logic [7:0] got;
    logic       b;
    rd_q.push_back(model_mem[model_ptr]);
    model_ptr = AW'(model_ptr + 1'b1);
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      got[i] = b;
    end
    chk(tag, 32'(got), 32'(rd_q.pop_front()));
    put_bit(nack);
  endtask

  // Write-strobe scoreboard
  always @(negedge clk) begin
    if (rstn && bus.wr_stb_o) begin
      stb_cnt++;
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 32'(bus.wr_stb_o), 32'h0);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr_o), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data_o), 32'(e.data));
      end
    end
    if (watch_low && !bus.sda_o) saw_low <= 1'b1;
  end

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic       b;
    logic [7:0] v;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;

    // Reset values
    tick(3);
    chk("rst_sda_o",     32'(bus.sda_o),     32'h1);
    chk("rst_busy_o",    32'(bus.busy_o),    32'h0);
    chk("rst_wr_stb_o",  32'(bus.wr_stb_o),  32'h0);
    chk("rst_wr_addr_o", 32'(bus.wr_addr_o), 32'h0);
    chk("rst_wr_data_o", 32'(bus.wr_data_o), 32'h0);
    rstn = 1'b1;
    tick(5);

    // Single register write
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    chk("busy_after_match", 32'(bus.busy_o), 32'h1);
    wr_ptr(8'h03);
    wr_data(8'hA5);
    bus_stop();
    tick(4);
    chk("busy_after_stop", 32'(bus.busy_o), 32'h0);
    chk("stb_count_write", 32'(stb_cnt), 32'd1);

    // Read back with repeated start and NACK
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'h03);
    bus_rstart();
    send_byte("addr_r_ack", 8'h45, 1'b0);
    rd_one("rd_reg3", 1'b1);
    chk("busy_after_nack", 32'(bus.busy_o), 32'h0);
    chk("sda_after_nack",  32'(bus.sda_o),  32'h1);
    bus_stop();

    // Burst write across the wrap, then burst read
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'd14);
    for (int i = 0; i < 4; i++) wr_data(8'(8'h10 + i));
    bus_stop();
    chk("stb_count_burst", 32'(stb_cnt), 32'd5);
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'd14);
    bus_rstart();
    send_byte("addr_r_ack", 8'h45, 1'b0);
    for (int i = 0; i < 4; i++) rd_one("rd_burst", (i == 3));
    bus_stop();

    // Foreign address: never acked, nothing written
    watch_low = 1'b1;
    bus_start();
    send_byte("mismatch_addr_nack", 8'h46, 1'b1);
    chk("busy_mismatch", 32'(bus.busy_o), 32'h0);
    send_byte("mismatch_data_nack", 8'h5A, 1'b1);
    bus_stop();
    watch_low = 1'b0;
    tick(2);
    chk("mismatch_sda_low", 32'(saw_low), 32'h0);
    chk("stb_count_mismatch", 32'(stb_cnt), 32'd5);

    // 32 incrementing bytes written, then read back
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'h00);
    for (int i = 0; i < 32; i++) wr_data(8'(i));
    bus_stop();
    chk("stb_count_32", 32'(stb_cnt), 32'd37);
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'h00);
    bus_rstart();
    send_byte("addr_r_ack", 8'h45, 1'b0);
    for (int i = 0; i < 32; i++) rd_one("rd_32", (i == 31));
    bus_stop();

    // Reset during bit 4 of a read of register 2
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'h02);
    bus_rstart();
    send_byte("addr_r_ack", 8'h45, 1'b0);
    v = model_mem[2];
    for (int i = 0; i < 4; i++) begin
      get_bit(b);
      chk("rd_partial_bit", 32'(b), 32'(v[7 - i]));
    end
    tick(Q);
    scl_m = 1'b1;
    tick(Q / 2);
    chk("pre_reset_sda_o", 32'(bus.sda_o), 32'(v[3]));
    rstn = 1'b0;
    #1;
    chk("reset_sda_o", 32'(bus.sda_o), 32'h1);
    chk("reset_busy_o", 32'(bus.busy_o), 32'h0);
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
    model_ptr = '0;
    tick(4);
    rstn = 1'b1;
    tick(10);
    bus_start();
    send_byte("addr_w_ack", 8'h44, 1'b0);
    wr_ptr(8'h00);
    bus_rstart();
    send_byte("addr_r_ack", 8'h45, 1'b0);
    rd_one("rd_after_reset", 1'b1);
    bus_stop();
    tick(4);
    chk("stb_count_final", 32'(stb_cnt), 32'd37);
    chk("wr_pending", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
